strhw_stream_feeder: RTL and testbench
======================================

Name: strhw_stream_feeder

Overview:
- Hardware message feeder for the Streebog core `strhw`. Replaces the file-driven block loop with synthesizable logic.
- Accepts a byte stream of parametrised width through a valid/ready handshake and packs it into 512-bit blocks.
- Drives the core's trigger, block, block size and hash size inputs, including the mandatory short or empty final block.
- Returns one hash per message, with a valid pulse.

Parameters:
- IN_BYTES, 8, bytes per input beat; must be 1, 2, 4, 8, 16, 32 or 64 so that no beat straddles a block.
- KW, $clog2(IN_BYTES+1), width of the byte-count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- s_data_i  in  IN_BYTES*8  stream data; byte k is bits [8k+7:8k], and byte 0 is first in message order.
- s_keep_i  in  KW  valid byte count of the beat; must equal IN_BYTES unless s_last_i is high; 0..IN_BYTES allowed on the last beat.
- s_valid_i  in  1  beat valid.
- s_last_i  in  1  final beat of the message.
- s_ready_o  out  1  feeder accepts a beat this cycle.
- hash_size_i  in  1  1 = 256-bit hash, 0 = 512-bit; sampled on the first beat of each message.
- core_trg_o  out  1  one-cycle trigger to strhw trg_i.
- core_block_o  out  512  to strhw block_i; message byte i at bits [8i+7:8i].
- core_block_size_o  out  7  to strhw block_size_i; 0..64.
- core_hash_size_o  out  1  to strhw hash_size_i.
- core_state_i  in  state_t  from strhw state_o.
- core_hash_i  in  512  from strhw hash_o.
- hash_o  out  512  captured result; held until the next capture.
- hash_valid_o  out  1  one-cycle pulse when hash_o updates.
- busy_o  out  1  high from the first accepted beat until the hash_valid_o pulse.

Behaviour:
- **Reset.** Asynchronous, active-high. While rst_i is high, all outputs are 0, the buffer is cleared, cnt = 0, and the state is FILL. If reset arrives mid-message, the message is abandoned and no hash_valid_o is issued.
- **Registers.** 512-bit buffer; cnt in 0..64 (7 bits); flags final, pend_empty and hsz.
- **Block output.** core_block_o = buffer and core_block_size_o = size register, both registered and stable from FIRE until the core finishes. Unused bytes of the buffer are always zero.
- **FILL** (s_ready_o = 1):
  - A beat is accepted when s_valid_i & s_ready_o. Its s_keep_i bytes are written to buffer bytes cnt..cnt+keep-1, and cnt += keep.
  - hsz <= hash_size_i on the first beat of a message.
  - If !s_last_i and cnt reaches 64: size = 64, final = 0, go to FIRE.
  - If s_last_i and cnt+keep < 64: size = cnt+keep, final = 1, go to FIRE.
  - If s_last_i and cnt+keep = 64: size = 64, final = 0, pend_empty = 1, go to FIRE.
- **FIRE** (s_ready_o = 0): core_trg_o = 1 for exactly one cycle, then go to SKIP.
- **SKIP:** one cycle in which core_state_i is ignored (core state update latency), then go to WAIT.
- **WAIT:** remain until core_state_i is READY or DONE. Then:
  - If final: go to CAPTURE.
  - Else if pend_empty: clear the buffer, size = 0, final = 1, clear pend_empty, go to FIRE.
  - Else: clear the buffer, cnt = 0, go to FILL.
- **CAPTURE:**
  - hash_o <= core_hash_i when hsz = 0.
  - hash_o <= {256'b0, core_hash_i[255:0]} when hsz = 1.
  - hash_valid_o = 1 for one cycle. Clear buffer, cnt and flags; go to FILL. The next message may start on the following cycle.
- **Empty message:** a single beat with s_last_i = 1 and s_keep_i = 0 yields one FIRE with size 0 and an all-zero block.
- **Message length a multiple of 64:** always produces a trailing size-0 block.
- **Back-pressure:** s_ready_o is 0 outside FILL. A held beat (s_valid_i stable) is accepted on re-entry to FILL. No beat is lost or duplicated.
- core_hash_size_o = hsz throughout the message.
- busy_o = (state != FILL) | (cnt != 0).

Test Plan (IN_BYTES = 8; behavioural strhw model with a configurable busy time):
1. Empty message (one beat, last = 1, keep = 0) -> exactly one core_trg_o pulse with block_size 0 and block 0. hash_valid_o pulses once, and hash_o equals the model hash.
2. 63-byte message with bytes 0x00..0x3E (7 full beats, then last with keep = 7) -> one trigger, size 7'h3F, block[7:0] = 8'h00, block[503:496] = 8'h3E, block[511:504] = 0.
3. 64-byte message -> two triggers: size 7'h40 with full data, then size 0 with block 0. One hash_valid_o pulse, after the second trigger only.
4. 130-byte message -> three triggers with sizes 64, 64, 2. The last block has bytes 128 and 129 at [15:0], with the rest zero.
5. Back-pressure: the model stays busy 20 cycles and the source holds s_valid_i high continuously -> s_ready_o is 0 during FIRE/SKIP/WAIT, every byte appears exactly once in order, and core_trg_o is never high for 2 consecutive cycles.
6. Two cases:
   - hash_size_i = 1 on the first beat: hash_o[511:256] = 0 and core_hash_size_o = 1 for every block.
   - rst_i pulsed during WAIT: all outputs read 0 during reset, no hash_valid_o is issued for the abandoned message, and the following 63-byte message reproduces scenario 2 exactly.

Source files
------------

// File: rtl/strhw_stream_feeder.sv
// Streebog message feeder: packs a valid/ready byte stream into 512-bit blocks,
// sequences the strhw core block by block and captures one hash per message.

package strhw_pkg;
  typedef enum logic [1:0] {
    READY = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

module strhw_stream_feeder
  import strhw_pkg::*;
#(
  parameter int IN_BYTES = 8,
  parameter int KW       = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IN_BYTES*8-1:0] s_data_i,
  input  logic [KW-1:0]         s_keep_i,
  input  logic                  s_valid_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  input  logic                  hash_size_i,
  output logic                  core_trg_o,
  output logic [511:0]          core_block_o,
  output logic [6:0]            core_block_size_o,
  output logic                  core_hash_size_o,
  input  state_t                core_state_i,
  input  logic [511:0]          core_hash_i,
  output logic [511:0]          hash_o,
  output logic                  hash_valid_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_FILL,
    S_FIRE,
    S_SKIP,
    S_WAIT,
    S_CAPTURE
  } fsm_t;

  fsm_t         state_q, state_d;
  logic [511:0] buf_q, buf_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [6:0]   size_q, size_d;
  logic         final_q, final_d;
  logic         pend_empty_q, pend_empty_d;
  logic         hsz_q, hsz_d;
  logic         in_msg_q, in_msg_d;
  logic [511:0] hash_q, hash_d;
  logic         hash_valid_q, hash_valid_d;

  logic         beat_fire;
  logic [7:0]   cnt_sum;
  logic [5:0]   wr_idx;
  logic         core_idle;

  assign beat_fire = s_valid_i && (state_q == S_FILL);
  assign cnt_sum   = 8'(cnt_q) + 8'(s_keep_i);
  assign core_idle = (core_state_i == READY) || (core_state_i == DONE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of inferred latches.
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    final_d      = final_q;
    pend_empty_d = pend_empty_q;
    hsz_d        = hsz_q;
    in_msg_d     = in_msg_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    wr_idx       = '0;

    unique case (state_q)
      S_FILL: begin
        if (beat_fire) begin
          // Beats never straddle a block, so cnt+k always stays below 64.
          for (int k = 0; k < IN_BYTES; k++) begin
            wr_idx = cnt_q[5:0] + 6'(k);
            if (KW'(k) < s_keep_i) buf_d[{wr_idx, 3'b000} +: 8] = s_data_i[8*k +: 8];
          end
          if (!in_msg_q) hsz_d = hash_size_i;
          in_msg_d = 1'b1;
          cnt_d    = cnt_sum[6:0];
          if (s_last_i) begin
            state_d = S_FIRE;
            if (cnt_sum < 8'd64) begin
              size_d  = cnt_sum[6:0];
              final_d = 1'b1;
            end else begin
              // A full last block still needs the empty closing block after it.
              size_d       = 7'd64;
              final_d      = 1'b0;
              pend_empty_d = 1'b1;
            end
          end else if (cnt_sum >= 8'd64) begin
            size_d  = 7'd64;
            final_d = 1'b0;
            state_d = S_FIRE;
          end
        end
      end

      S_FIRE: state_d = S_SKIP;

      // The core's state output lags the trigger by a cycle; ignore it here.
      S_SKIP: state_d = S_WAIT;

      S_WAIT: begin
        if (core_idle) begin
          if (final_q) begin
            state_d = S_CAPTURE;
          end else if (pend_empty_q) begin
            buf_d        = '0;
            size_d       = 7'd0;
            final_d      = 1'b1;
            pend_empty_d = 1'b0;
            state_d      = S_FIRE;
          end else begin
            buf_d   = '0;
            cnt_d   = 7'd0;
            state_d = S_FILL;
          end
        end
      end

      S_CAPTURE: begin
        hash_d       = hsz_q ? {256'b0, core_hash_i[255:0]} : core_hash_i;
        hash_valid_d = 1'b1;
        buf_d        = '0;
        cnt_d        = 7'd0;
        final_d      = 1'b0;
        pend_empty_d = 1'b0;
        hsz_d        = 1'b0;
        in_msg_d     = 1'b0;
        state_d      = S_FILL;
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_FILL;
      // NOTE: the block buffer is reset on purpose: unused bytes must read as
      // zero on the core input, including the first block after reset.
      buf_q        <= '0;
      cnt_q        <= 7'd0;
      size_q       <= 7'd0;
      final_q      <= 1'b0;
      pend_empty_q <= 1'b0;
      hsz_q        <= 1'b0;
      in_msg_q     <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      final_q      <= final_d;
      pend_empty_q <= pend_empty_d;
      hsz_q        <= hsz_d;
      in_msg_q     <= in_msg_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  // Ready is masked by reset so that every output reads zero while reset is held.
  assign s_ready_o         = (state_q == S_FILL) && !rst_i;
  assign core_trg_o        = (state_q == S_FIRE);
  assign core_block_o      = buf_q;
  assign core_block_size_o = size_q;
  assign core_hash_size_o  = hsz_q;
  assign hash_o            = hash_q;
  assign hash_valid_o      = hash_valid_q;
  assign busy_o            = (state_q != S_FILL) || (cnt_q != 7'd0);

endmodule

// File: tb/tb_strhw_stream_feeder.sv
// Directed bench for strhw_stream_feeder with a behavioural strhw core model
// whose busy time is set per message.

module tb_strhw_stream_feeder;
  import strhw_pkg::*;

  localparam int IN_BYTES = 8;
  localparam int KW       = $clog2(IN_BYTES + 1);
  localparam logic [511:0] IV = {8{64'h0123456789ABCDEF}};

  logic                  clk = 1'b0;
  logic                  rst;
  logic [IN_BYTES*8-1:0] s_data_i;
  logic [KW-1:0]         s_keep_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_ready_o;
  logic                  hash_size_i;
  logic                  core_trg_o;
  logic [511:0]          core_block_o;
  logic [6:0]            core_block_size_o;
  logic                  core_hash_size_o;
  state_t                core_state_i;
  logic [511:0]          core_hash_i;
  logic [511:0]          hash_o;
  logic                  hash_valid_o;
  logic                  busy_o;

  int checks = 0;
  int errors = 0;

  strhw_stream_feeder #(.IN_BYTES(IN_BYTES)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .s_data_i          (s_data_i),
    .s_keep_i          (s_keep_i),
    .s_valid_i         (s_valid_i),
    .s_last_i          (s_last_i),
    .s_ready_o         (s_ready_o),
    .hash_size_i       (hash_size_i),
    .core_trg_o        (core_trg_o),
    .core_block_o      (core_block_o),
    .core_block_size_o (core_block_size_o),
    .core_hash_size_o  (core_hash_size_o),
    .core_state_i      (core_state_i),
    .core_hash_i       (core_hash_i),
    .hash_o            (hash_o),
    .hash_valid_o      (hash_valid_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Toy compression: rotate, fold in block and size. Stands in for Streebog.
  function automatic logic [511:0] mix(input logic [511:0] h, input logic [511:0] b,
                                       input logic [6:0] s);
    return {h[510:0], h[511]} ^ b ^ {505'd0, s};
  endfunction

  function automatic logic [7:0] msg_byte(input int base, input int i);
    return 8'((base + i) & 255);
  endfunction

  function automatic logic [511:0] exp_blk(input int n, input int base, input int j);
    logic [511:0] blk;
    int rem;
    blk = '0;
    rem = n - 64 * j;
    for (int k = 0; k < 64; k++) if (k < rem) blk[8*k +: 8] = msg_byte(base, 64 * j + k);
    return blk;
  endfunction

  function automatic logic [6:0] exp_size(input int n, input int j);
    int rem;
    rem = n - 64 * j;
    return (rem >= 64) ? 7'd64 : 7'(rem);
  endfunction

  // ---------------- behavioural core model ----------------
  int           busy_time;
  int           bcnt;
  logic [511:0] mh;
  bit           newmsg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_state_i <= READY;
      core_hash_i  <= '0;
      mh           <= '0;
      newmsg       <= 1'b1;
      bcnt         <= 0;
    end else if (core_trg_o) begin
      mh           <= mix(newmsg ? IV : mh, core_block_o, core_block_size_o);
      newmsg       <= (core_block_size_o < 7'd64);
      core_state_i <= BUSY;
      bcnt         <= busy_time;
    end else if (core_state_i == BUSY) begin
      if (bcnt <= 1) begin
        core_state_i <= DONE;
        core_hash_i  <= mh;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [6:0]   trg_size_q[$];
  logic [511:0] trg_blk_q[$];
  logic         trg_hsz_q[$];
  logic         prev_trg = 1'b0;
  int           hv_count = 0;
  int           trg_at_hv = 0;
  logic [511:0] hv_hash = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (core_trg_o) begin
        check("trg_back_to_back", 512'(prev_trg), 512'(0));
        check("ready_during_fire", 512'(s_ready_o), 512'(0));
        trg_size_q.push_back(core_block_size_o);
        trg_blk_q.push_back(core_block_o);
        trg_hsz_q.push_back(core_hash_size_o);
      end
      if (core_state_i == BUSY) check("ready_while_core_busy", 512'(s_ready_o), 512'(0));
      if (hash_valid_o) begin
        hv_count++;
        hv_hash   = hash_o;
        trg_at_hv = trg_size_q.size();
      end
    end
    prev_trg = core_trg_o;
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_msg(input int n, input int base, input logic hs);
    int nb;
    int kp;
    int w;
    nb = (n == 0) ? 1 : (n + IN_BYTES - 1) / IN_BYTES;
    for (int b = 0; b < nb; b++) begin
      kp = (b == nb - 1) ? n - IN_BYTES * b : IN_BYTES;
      @(negedge clk);
      s_valid_i   = 1'b1;
      s_last_i    = (b == nb - 1);
      s_keep_i    = KW'(kp);
      hash_size_i = (b == 0) ? hs : ~hs;
      for (int k = 0; k < IN_BYTES; k++)
        s_data_i[8*k +: 8] = (k < kp) ? msg_byte(base, IN_BYTES * b + k) : 8'hA5;
      w = 0;
      while (!s_ready_o && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check("ready_timeout", 512'(w < 2000), 512'(1));
      @(posedge clk);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic run_msg(input int n, input int base, input logic hs, input int busy);
    int w;
    int nb;
    logic [511:0] h;
    busy_time = busy;
    trg_size_q.delete();
    trg_blk_q.delete();
    trg_hsz_q.delete();
    hv_count = 0;
    send_msg(n, base, hs);
    w = 0;
    while (hv_count == 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("hash_valid_timeout", 512'(w < 3000), 512'(1));
    repeat (5) @(negedge clk);
    nb = n / 64 + 1;
    check("hash_valid_pulses", 512'(hv_count), 512'(1));
    check("trigger_count", 512'(trg_size_q.size()), 512'(nb));
    check("triggers_before_hash", 512'(trg_at_hv), 512'(nb));
    check("busy_after_hash", 512'(busy_o), 512'(0));
    h = IV;
    for (int j = 0; j < nb; j++) begin
      h = mix(h, exp_blk(n, base, j), exp_size(n, j));
      if (j < trg_size_q.size()) begin
        check($sformatf("block_size[%0d]", j), 512'(trg_size_q[j]), 512'(exp_size(n, j)));
        check($sformatf("block_data[%0d]", j), trg_blk_q[j], exp_blk(n, base, j));
        check($sformatf("block_hsz[%0d]", j), 512'(trg_hsz_q[j]), 512'(hs));
      end
    end
    check("hash", hv_hash, hs ? {256'b0, h[255:0]} : h);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 512'(s_ready_o), 512'(0));
    check({tag, "_trg"}, 512'(core_trg_o), 512'(0));
    check({tag, "_block"}, core_block_o, 512'(0));
    check({tag, "_size"}, 512'(core_block_size_o), 512'(0));
    check({tag, "_hsz"}, 512'(core_hash_size_o), 512'(0));
    check({tag, "_hash"}, hash_o, 512'(0));
    check({tag, "_hash_valid"}, 512'(hash_valid_o), 512'(0));
    check({tag, "_busy"}, 512'(busy_o), 512'(0));
  endtask

  task automatic check_scenario2(input string tag);
    if (trg_blk_q.size() > 0) begin
      check({tag, "_size"}, 512'(trg_size_q[0]), 512'(7'h3F));
      check({tag, "_byte0"}, 512'(trg_blk_q[0][7:0]), 512'(8'h00));
      check({tag, "_byte62"}, 512'(trg_blk_q[0][503:496]), 512'(8'h3E));
      check({tag, "_byte63"}, 512'(trg_blk_q[0][511:504]), 512'(8'h00));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    rst         = 1'b1;
    s_valid_i   = 1'b0;
    s_last_i    = 1'b0;
    s_keep_i    = '0;
    s_data_i    = '0;
    hash_size_i = 1'b0;
    busy_time   = 4;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 512'(s_ready_o), 512'(1));

    // 1: empty message
    run_msg(0, 0, 1'b0, 3);
    // 2: 63 bytes 0x00..0x3E
    run_msg(63, 0, 1'b0, 4);
    check_scenario2("s2");
    // 3: 64 bytes -> full block then empty block
    run_msg(64, 8'h40, 1'b0, 3);
    // 4: 130 bytes -> 64, 64, 2
    run_msg(130, 0, 1'b0, 2);
    if (trg_blk_q.size() == 3)
      check("s4_tail", trg_blk_q[2], {496'd0, 8'h81, 8'h80});
    // 5: long core busy time with source held valid
    run_msg(100, 17, 1'b0, 20);
    // 6a: 256-bit hash selection
    run_msg(80, 3, 1'b1, 6);
    check("s6_hash_upper_zero", 512'(hv_hash[511:256]), 512'(0));

    // 6b: reset while waiting on the core
    busy_time = 30;
    hv_count  = 0;
    send_msg(20, 5, 1'b1);
    w = 0;
    while (core_state_i != BUSY && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("abandon_core_busy_timeout", 512'(w < 100), 512'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset_held");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abandoned_no_hash_valid", 512'(hv_count), 512'(0));
    run_msg(63, 0, 1'b0, 4);
    check_scenario2("s6_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
